// File: rtl/alu_md_pkg.sv
// alu_md_pkg: aluop codes, MD FSM states and decode helper for alu_md (ALU_OVF_EN-agnostic)
package alu_md_pkg;
   localparam logic [4:0] ADDU = 5'd0, SUBU = 5'd1, ADD = 5'd2, AND = 5'd3, OR = 5'd4,
                          SLT = 5'd5, LUI = 5'd6, SLTU = 5'd7, XOR = 5'd8, NOR = 5'd9,
                          SLL = 5'd10, SRL = 5'd11, SRA = 5'd12, SUB = 5'd13,
                          MULT = 5'd16, MULTU = 5'd17, DIV = 5'd18, DIVU = 5'd19,
                          MFHI = 5'd20, MFLO = 5'd21, MTHI = 5'd22, MTLO = 5'd23;
   typedef enum logic [1:0] {IDLE, RUN, FIN} md_state_e;
   function automatic logic is_md_iter(input logic [4:0] op);
      return op inside {MULT, MULTU, DIV, DIVU};
   endfunction
endpackage

// File: rtl/alu_md_if.sv
// alu_md_if: operand/result bundle between the EX stage (master) and alu_md (slave)
interface alu_md_if #(parameter int WIDTH = 32, parameter int AOP_W = 5);
   logic [WIDTH-1:0] a, b, c, hi, lo;
   logic [AOP_W-1:0] aluop;
   logic md_start, zero, ovf, md_busy, md_stall, md_done;
   modport master (output a, b, aluop, md_start,
                   input c, zero, ovf, md_busy, md_stall, md_done, hi, lo);
   modport slave (input a, b, aluop, md_start,
                  output c, zero, ovf, md_busy, md_stall, md_done, hi, lo);
endinterface

// File: rtl/alu_md_md_iter.sv
// alu_md_md_iter: radix-2 shift-add multiplier / restoring divider on magnitudes, sign fixed at FIN
module alu_md_md_iter import alu_md_pkg::*; #(parameter int WIDTH = 32) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt,
   output logic             wr,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);
   md_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] m_q, m_d, acc_q, acc_d, q_q, q_d;
   logic div_q, div_d, na_q, na_d, nb_q, nb_d, dz_q, dz_d, done_q, done_d;
   logic sgn;
   logic [WIDTH:0] sum, sh, diff;
   logic [2*WIDTH-1:0] prod, prod_f;
   always_comb begin
      sgn = op == MULT || op == DIV;
      sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
      sh = {acc_q, q_q[WIDTH-1]};
      diff = sh - {1'b0, m_q};
      state_d = state_q == IDLE ? (start ? RUN : IDLE) :
                state_q == RUN ? (cnt_q == CW'(WIDTH - 1) ? FIN : RUN) : IDLE;
      cnt_d = state_q == RUN ? cnt_q + 1'b1 : '0;
      {m_d, acc_d, q_d, div_d, na_d, nb_d, dz_d} = {m_q, acc_q, q_q, div_q, na_q, nb_q, dz_q};
      if (state_q == IDLE && start) begin
         na_d = sgn & a[WIDTH-1];
         nb_d = sgn & b[WIDTH-1];
         q_d = na_d ? -a : a;
         m_d = nb_d ? -b : b;
         acc_d = '0;
         div_d = op == DIV || op == DIVU;
         dz_d = b == '0;
      end else if (state_q == RUN) begin
         acc_d = div_q ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
         q_d = div_q ? {q_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q_q[WIDTH-1:1]};
      end
      done_d = state_q == FIN;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         {cnt_q, m_q, acc_q, q_q, div_q, na_q, nb_q, dz_q, done_q} <= '0;
      end else begin
         state_q <= state_d;
         {cnt_q, m_q, acc_q, q_q, div_q, na_q, nb_q, dz_q, done_q} <=
            {cnt_d, m_d, acc_d, q_d, div_d, na_d, nb_d, dz_d, done_d};
      end
   // Remainder follows the dividend; divide-by-zero forces an all-ones quotient
   always_comb begin
      prod = {acc_q, q_q};
      prod_f = (na_q ^ nb_q) ? -prod : prod;
      hi_nxt = div_q ? (na_q ? -acc_q : acc_q) : prod_f[2*WIDTH-1:WIDTH];
      lo_nxt = div_q ? (dz_q ? '1 : ((na_q ^ nb_q) ? -q_q : q_q)) : prod_f[WIDTH-1:0];
   end
   assign wr = state_q == FIN;
   assign busy = state_q != IDLE;
   assign done = done_q;
endmodule

// File: rtl/alu_md.sv
// alu_md: EX-stage ALU with iterative mul/div and HI/LO; `define ALU_OVF_EN enables ADD/SUB overflow
module alu_md import alu_md_pkg::*; #(parameter int WIDTH = 32, parameter int AOP_W = 5) (
   input logic      clk,
   input logic      rst_n,
   alu_md_if.slave  bus
);
   localparam int SW = $clog2(WIDTH);
   logic [4:0] op;
   logic [SW-1:0] shamt;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, hi_nxt, lo_nxt, sum, dif;
   logic wr, busy, iter, mt_ok;
   assign op = 5'(bus.aluop);
   assign iter = is_md_iter(op);
   assign shamt = bus.a[SW-1:0];
   assign sum = bus.a + bus.b;
   assign dif = bus.a - bus.b;
   alu_md_md_iter #(.WIDTH(WIDTH)) u_md_iter (
      .clk, .rst_n, .start(bus.md_start & iter & ~busy), .op, .a(bus.a), .b(bus.b),
      .hi_nxt, .lo_nxt, .wr, .busy, .done(bus.md_done));
   always_comb begin
      case (op)
         ADDU, ADD: bus.c = sum;
         SUBU, SUB: bus.c = dif;
         AND:       bus.c = bus.a & bus.b;
         OR:        bus.c = bus.a | bus.b;
         XOR:       bus.c = bus.a ^ bus.b;
         NOR:       bus.c = ~(bus.a | bus.b);
         SLT:       bus.c = WIDTH'($signed(bus.a) < $signed(bus.b));
         SLTU:      bus.c = WIDTH'(bus.a < bus.b);
         LUI:       bus.c = bus.b << (WIDTH / 2);
         SLL:       bus.c = bus.b << shamt;
         SRL:       bus.c = bus.b >> shamt;
         SRA:       bus.c = $signed(bus.b) >>> shamt;
         MFHI:      bus.c = hi_q;
         MFLO:      bus.c = lo_q;
         default:   bus.c = '0;
      endcase
   end
`ifdef ALU_OVF_EN
   assign bus.ovf = op == ADD ? (bus.a[WIDTH-1] == bus.b[WIDTH-1] && sum[WIDTH-1] != bus.a[WIDTH-1]) :
                    op == SUB ? (bus.a[WIDTH-1] != bus.b[WIDTH-1] && dif[WIDTH-1] != bus.a[WIDTH-1]) : 1'b0;
`else
   assign bus.ovf = 1'b0;
`endif
   // MTHI/MTLO are single-cycle writes, accepted only while the iterative unit is idle
   assign mt_ok = bus.md_start & ~busy;
   always_comb begin
      hi_d = wr ? hi_nxt : (mt_ok && op == MTHI) ? bus.a : hi_q;
      lo_d = wr ? lo_nxt : (mt_ok && op == MTLO) ? bus.a : lo_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   assign bus.zero = bus.a == bus.b;
   assign bus.md_busy = busy;
   assign bus.md_stall = busy | (bus.md_start & iter);
   assign bus.hi = hi_q;
   assign bus.lo = lo_q;
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: scoreboard bench for alu_md at WIDTH=32 and WIDTH=16 (honours ALU_OVF_EN)
module tb_alu_md;
   import alu_md_pkg::*;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
`ifdef ALU_OVF_EN
   localparam logic OVF = 1'b1;
`else
   localparam logic OVF = 1'b0;
`endif
   alu_md_if #(.WIDTH(32), .AOP_W(5)) b32 ();
   alu_md_if #(.WIDTH(16), .AOP_W(5)) b16 ();
   alu_md #(.WIDTH(32), .AOP_W(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
   alu_md #(.WIDTH(16), .AOP_W(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
   typedef struct {string tag; logic [63:0] v;} exp_t;
   exp_t sb[$];
   int n_chk = 0, n_err = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic sb_push(input string tag, input logic [63:0] v);
      exp_t e;
      e.tag = tag;
      e.v = v;
      sb.push_back(e);
   endtask
   task automatic sb_pop(input logic [63:0] got);
      exp_t e;
      if (sb.size() == 0) check("sb_empty", 64'(sb.size()), 64'd1);
      else begin
         e = sb.pop_front();
         check(e.tag, got, e.v);
      end
   endtask
   task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
      b32.md_start = 0;
      b32.aluop = op;
      b32.a = a;
      b32.b = b;
      sb_push(tag, 64'(exp));
      #1;
      sb_pop(64'(b32.c));
   endtask
   task automatic md(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input bit poke);
      int stall = 0;
      @(posedge clk);
      #1;
      b32.aluop = op;
      b32.a = a;
      b32.b = b;
      b32.md_start = 1;
      sb_push(tag, exp);
      #1;
      while (b32.md_stall && stall < 100) begin
         stall++;
         @(posedge clk);
         #1;
         b32.md_start = poke && stall == 5;
         if (b32.md_start) begin
            b32.aluop = MULT;
            b32.a = 32'd9;
            b32.b = 32'd9;
         end
         #1;
      end
      check({tag, "_stall"}, 64'(stall), 64'd34);
      sb_pop({b32.hi, b32.lo});
      check({tag, "_done"}, 64'(b32.md_done), 64'd1);
      @(posedge clk);
      #2;
      check({tag, "_done_once"}, 64'(b32.md_done), 64'd0);
   endtask
   initial begin
      int stall;
      {b32.a, b32.b, b32.aluop, b32.md_start} = '0;
      {b16.a, b16.b, b16.aluop, b16.md_start} = '0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_hi", 64'(b32.hi), 64'd0);
      check("rst_lo", 64'(b32.lo), 64'd0);
      check("rst_busy", 64'(b32.md_busy), 64'd0);
      check("rst_done", 64'(b32.md_done), 64'd0);
      rst_n = 1;
      alu("add", ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000);
      check("add_ovf", 64'(b32.ovf), 64'(OVF));
      alu("addu", ADDU, 32'h7FFFFFFF, 32'h1, 32'h80000000);
      check("addu_ovf", 64'(b32.ovf), 64'd0);
      alu("sub", SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF);
      check("sub_ovf", 64'(b32.ovf), 64'(OVF));
      alu("subu", SUBU, 32'h80000000, 32'h1, 32'h7FFFFFFF);
      check("subu_ovf", 64'(b32.ovf), 64'd0);
      alu("sra", SRA, 32'h4, 32'h80000000, 32'hF8000000);
      alu("srl", SRL, 32'h4, 32'h80000000, 32'h08000000);
      alu("sll", SLL, 32'h1F, 32'h1, 32'h80000000);
      alu("slt", SLT, 32'hFFFFFFFF, 32'h1, 32'h1);
      alu("sltu", SLTU, 32'hFFFFFFFF, 32'h1, 32'h0);
      alu("lui", LUI, 32'h0, 32'h1234, 32'h12340000);
      alu("and", AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
      alu("or", OR, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
      alu("xor", XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
      alu("nor", NOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F);
      check("zero_ne", 64'(b32.zero), 64'd0);
      alu("md_code_c", MULT, 32'h5, 32'h5, 32'h0);
      check("zero_eq", 64'(b32.zero), 64'd1);
      md("mult", MULT, 32'hFFFFFFFE, 32'h3, 64'hFFFFFFFF_FFFFFFFA, 0);
      md("div", DIV, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 0);
      md("divu_z", DIVU, 32'h7, 32'h0, 64'h00000007_FFFFFFFF, 0);
      alu("mfhi", MFHI, 32'h0, 32'h0, 32'h7);
      alu("mflo", MFLO, 32'h0, 32'h0, 32'hFFFFFFFF);
      md("div_min", DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0);
      md("div_z_neg", DIV, 32'hFFFFFFF9, 32'h0, 64'hFFFFFFF9_FFFFFFFF, 0);
      md("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0);
      md("mult_poke", MULT, 32'h5, 32'h7, 64'h23, 1);
      @(posedge clk);
      #1;
      b32.aluop = MTHI;
      b32.a = 32'h55;
      b32.md_start = 1;
      #1;
      check("mthi_stall", 64'(b32.md_stall), 64'd0);
      @(posedge clk);
      #1;
      b32.md_start = 0;
      #1;
      check("mthi_hi", 64'(b32.hi), 64'h55);
      check("mthi_lo_kept", 64'(b32.lo), 64'h23);
      check("mthi_done", 64'(b32.md_done), 64'd0);
      check("mthi_busy", 64'(b32.md_busy), 64'd0);
      @(posedge clk);
      #1;
      b32.aluop = MULTU;
      b32.a = 32'h1234;
      b32.b = 32'h5678;
      b32.md_start = 1;
      @(posedge clk);
      #1;
      b32.md_start = 0;
      repeat (10) @(posedge clk);
      #1;
      check("run_busy", 64'(b32.md_busy), 64'd1);
      rst_n = 0;
      #1;
      check("arst_busy", 64'(b32.md_busy), 64'd0);
      check("arst_hi", 64'(b32.hi), 64'd0);
      check("arst_lo", 64'(b32.lo), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1;
      md("multu_after_rst", MULTU, 32'h5, 32'h6, 64'h1E, 0);
      @(posedge clk);
      #1;
      b16.aluop = MULT;
      b16.a = 16'hFFFE;
      b16.b = 16'h3;
      b16.md_start = 1;
      sb_push("mult16", 64'hFFFF_FFFA);
      stall = 0;
      #1;
      while (b16.md_stall && stall < 100) begin
         stall++;
         @(posedge clk);
         #1;
         b16.md_start = 0;
         #1;
      end
      check("mult16_stall", 64'(stall), 64'd18);
      sb_pop(64'({b16.hi, b16.lo}));
      check("mult16_done", 64'(b16.md_done), 64'd1);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
